// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core.
//   DATA_W / REG_W / ALUOP_W : datapath, register specifier and ALU op class widths
//   BCNT_W                   : width of the pipeline bubble counter
//   alu_op_e                 : ALU op class encodings
//   ctrl_t                   : decoded control bundle carried from ID into EX
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned BCNT_W  = 16;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: raises stall when the load now in EX writes a
// register that the instruction in ID reads.
//   ex_valid, ex_mem_read, ex_rt : the instruction currently in EX
//   id_valid, id_rs, id_rt       : the instruction currently in ID
//   id_uses_rt                   : ID reads rt as a source operand
//   stall                        : combinational hazard flag
module load_use_detect
  import mips_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             stall
);

  // $zero as load target is never a real dependency
  assign stall = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                 ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// bubble counter.
//   Inputs : clk, rst_n (sync, active low), id_* decoded instruction, flush
//   Outputs: ex_* registered instruction, stall (combinational), bubble_cnt
// Build option: LOAD_USE_DETECT_EN enables load-use hazard detection; when it
// is undefined stall is tied low and only flush creates bubbles.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm_ext,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               id_uses_rt,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               flush,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm_ext,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               stall,
  output logic [BCNT_W-1:0]  bubble_cnt
);

  localparam logic [BCNT_W-1:0] CNT_MAX = '1;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  bubble_c;

  // Pack the ID control bits into the shared bundle
  assign id_ctrl = '{reg_write:  id_reg_write,
                     mem_to_reg: id_mem_to_reg,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     alu_src:    id_alu_src,
                     reg_dst:    id_reg_dst,
                     alu_op:     id_alu_op};

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_alu_op     = ex_ctrl.alu_op;

`ifdef LOAD_USE_DETECT_EN
  load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .stall       (stall)
  );
`else
  // Software schedules load delay slots; rt-use information is not needed
  logic unused_id_uses_rt;
  assign unused_id_uses_rt = id_uses_rt;
  assign stall             = 1'b0;
`endif

  // flush and stall together still collapse into one bubble
  assign bubble_c = flush | stall;

  // Pipeline register: reset > bubble > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm_ext <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      bubble_cnt <= '0;
    end else if (bubble_c) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm_ext <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      // Only squashed real instructions count, and the count saturates
      if (id_valid && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + BCNT_W'(1);
      end
    end else begin
      ex_valid   <= id_valid;
      ex_ctrl    <= id_valid ? id_ctrl : '0;
      ex_pc4     <= id_pc4;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm_ext <= id_imm_ext;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Expected values are hand-derived; the
// stall-dependent ones follow whether LOAD_USE_DETECT_EN is defined.
module tb_id_ex_stage;

`ifdef LOAD_USE_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst;
  logic [1:0]  id_alu_op;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
  logic [1:0]  ex_alu_op;
  logic        stall;
  logic [15:0] bubble_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_cnt;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .flush(flush), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ID instruction; PC+4 advances by 4 on every call
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic ur, input logic rw,
                        input logic m2r, input logic mr, input logic mw,
                        input logic asrc, input logic rdst, input logic [1:0] aop,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur;
    id_reg_write = rw; id_mem_to_reg = m2r; id_mem_read = mr; id_mem_write = mw;
    id_alu_src = asrc; id_reg_dst = rdst; id_alu_op = aop;
    id_rs_data = rsd; id_rt_data = rtd; id_imm_ext = imm;
    id_pc4 = id_pc4 + 32'd4;
    #1;
  endtask

  task automatic set_lw(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] imm);
    set_id(1'b1, rs, rt, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00,
           32'h100, 32'h0, imm);
  endtask

  task automatic set_rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] rsd, input logic [31:0] rtd);
    set_id(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
           rsd, rtd, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    id_pc4 = 32'h0000_0100;
    set_rtype(5'd3, 5'd1, 5'd2, 32'h11, 32'h22);
    tick();
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", ex_valid); end
    n_cmp++; if (ex_rs_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs_data: got %0h want 0", ex_rs_data); end
    n_cmp++; if (ex_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0h want 0", ex_rd); end
    n_cmp++; if (ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write: got %0h want 0", ex_reg_write); end
    n_cmp++; if (bubble_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0h want 0", bubble_cnt); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0h want 0", stall); end
    exp_cnt = 16'h0;
  endtask

  task automatic test_plain();
    rst_n = 1'b1;
    set_rtype(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL plain_valid: got %0h want 1", ex_valid); end
    n_cmp++; if (ex_rs_data !== 32'd5) begin n_fail++; $display("FAIL plain_rs_data: got %0h want 5", ex_rs_data); end
    n_cmp++; if (ex_rt_data !== 32'd7) begin n_fail++; $display("FAIL plain_rt_data: got %0h want 7", ex_rt_data); end
    n_cmp++; if (ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL plain_reg_write: got %0h want 1", ex_reg_write); end
    n_cmp++; if (ex_rd !== 5'd3) begin n_fail++; $display("FAIL plain_rd: got %0h want 3", ex_rd); end
    n_cmp++; if (ex_alu_op !== 2'b10) begin n_fail++; $display("FAIL plain_alu_op: got %0h want 2", ex_alu_op); end
    n_cmp++; if (ex_pc4 !== 32'h0000_0108) begin n_fail++; $display("FAIL plain_pc4: got %0h want 108", ex_pc4); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL plain_stall: got %0h want 0", stall); end
  endtask

  task automatic test_load_use_rs();
    set_lw(5'd2, 5'd0, 32'd4);
    tick();
    n_cmp++; if (ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL lw_mem_read: got %0h want 1", ex_mem_read); end
    n_cmp++; if (ex_imm_ext !== 32'd4) begin n_fail++; $display("FAIL lw_imm: got %0h want 4", ex_imm_ext); end
    set_rtype(5'd4, 5'd2, 5'd5, 32'h0, 32'h0);
    n_cmp++; if (stall !== HAZ) begin n_fail++; $display("FAIL rs_stall: got %0h want %0h", stall, HAZ); end
    tick();
    if (HAZ) exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (ex_valid !== !HAZ) begin n_fail++; $display("FAIL rs_bubble_valid: got %0h want %0h", ex_valid, !HAZ); end
    n_cmp++; if (ex_reg_write !== !HAZ) begin n_fail++; $display("FAIL rs_bubble_rw: got %0h want %0h", ex_reg_write, !HAZ); end
    n_cmp++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL rs_cnt: got %0h want %0h", bubble_cnt, exp_cnt); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rs_stall_one_cycle: got %0h want 0", stall); end
    tick();
    n_cmp++; if (ex_rd !== 5'd4 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL rs_add_arrives: got rd=%0h v=%0h want rd=4 v=1", ex_rd, ex_valid); end
  endtask

  task automatic test_load_use_rt();
    set_lw(5'd2, 5'd3, 32'd0);
    tick();
    set_id(1'b1, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00,
           32'h60, 32'h20, 32'h0);
    n_cmp++; if (stall !== HAZ) begin n_fail++; $display("FAIL rt_stall: got %0h want %0h", stall, HAZ); end
    tick();
    if (HAZ) exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (ex_mem_write !== !HAZ) begin n_fail++; $display("FAIL rt_bubble_mw: got %0h want %0h", ex_mem_write, !HAZ); end
    tick();
    n_cmp++; if (ex_mem_write !== 1'b1) begin n_fail++; $display("FAIL rt_sw_arrives: got %0h want 1", ex_mem_write); end
    set_lw(5'd2, 5'd3, 32'd0);
    tick();
    set_id(1'b1, 5'd7, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
           32'h70, 32'h0, 32'h9);
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL addi_no_stall: got %0h want 0", stall); end
    tick();
    n_cmp++; if (ex_alu_src !== 1'b1 || ex_imm_ext !== 32'h9) begin n_fail++; $display("FAIL addi_loaded: got src=%0h imm=%0h want src=1 imm=9", ex_alu_src, ex_imm_ext); end
    n_cmp++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL rt_cnt: got %0h want %0h", bubble_cnt, exp_cnt); end
  endtask

  task automatic test_zero_dest();
    set_lw(5'd0, 5'd1, 32'd0);
    tick();
    set_rtype(5'd3, 5'd0, 5'd0, 32'h0, 32'h0);
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %0h want 0", stall); end
    tick();
    n_cmp++; if (ex_rd !== 5'd3 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL zero_add: got rd=%0h v=%0h want rd=3 v=1", ex_rd, ex_valid); end
  endtask

  task automatic test_flush_stall();
    set_lw(5'd2, 5'd0, 32'd8);
    tick();
    set_rtype(5'd4, 5'd2, 5'd5, 32'h0, 32'h0);
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== HAZ) begin n_fail++; $display("FAIL fs_stall: got %0h want %0h", stall, HAZ); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin n_fail++; $display("FAIL fs_bubble: got v=%0h rd=%0h want v=0 rd=0", ex_valid, ex_rd); end
    n_cmp++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL fs_single_count: got %0h want %0h", bubble_cnt, exp_cnt); end
    flush = 1'b0;
    set_rtype(5'd10, 5'd8, 5'd9, 32'h8, 32'h9);
    tick();
    n_cmp++; if (ex_rd !== 5'd10) begin n_fail++; $display("FAIL fs_no_duplicate: got rd=%0h want a", ex_rd); end
  endtask

  task automatic test_invalid_id();
    set_id(1'b0, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10,
           32'hDEAD_BEEF, 32'h1234, 32'h5);
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid: got %0h want 0", ex_valid); end
    n_cmp++; if ({ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst, ex_alu_op} !== 8'h0)
      begin n_fail++; $display("FAIL inv_ctrl: got %0h want 0", {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst, ex_alu_op}); end
    n_cmp++; if (ex_rs_data !== 32'hDEAD_BEEF || ex_rd !== 5'd13) begin n_fail++; $display("FAIL inv_data: got %0h/%0h want deadbeef/d", ex_rs_data, ex_rd); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL inv_flush_cnt: got %0h want %0h", bubble_cnt, exp_cnt); end
    n_cmp++; if (ex_rs_data !== 32'h0) begin n_fail++; $display("FAIL bubble_data_zero: got %0h want 0", ex_rs_data); end
  endtask

  task automatic test_saturation_reset();
    int unsigned n;
    set_rtype(5'd3, 5'd1, 5'd2, 32'h1, 32'h2);
    flush = 1'b1;
    n = 32'hFFFE - 32'(exp_cnt);
    for (int i = 0; i < int'(n); i++) tick();
    n_cmp++; if (bubble_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe: got %0h want fffe", bubble_cnt); end
    tick();
    n_cmp++; if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff: got %0h want ffff", bubble_cnt); end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0h want ffff", bubble_cnt); end
    flush = 1'b0;
    set_lw(5'd2, 5'd0, 32'd4);
    tick();
    set_rtype(5'd4, 5'd2, 5'd5, 32'h3, 32'h4);
    flush = 1'b1;
    rst_n = 1'b0;
    tick();
    n_cmp++; if (bubble_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0h want 0", bubble_cnt); end
    n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rt !== 5'd0) begin n_fail++; $display("FAIL mid_reset_ex: got v=%0h mr=%0h rt=%0h want 0", ex_valid, ex_mem_read, ex_rt); end
    n_cmp++; if (ex_pc4 !== 32'h0 || ex_imm_ext !== 32'h0) begin n_fail++; $display("FAIL mid_reset_data: got %0h/%0h want 0", ex_pc4, ex_imm_ext); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stall: got %0h want 0", stall); end
    rst_n = 1'b1;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_plain();
    test_load_use_rs();
    test_load_use_rt();
    test_zero_dest();
    test_flush_stall();
    test_invalid_id();
    test_saturation_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
